// File: rtl/mips_pkg.sv
// Shared constants and types for the five-stage MIPS pipeline.
// Used by execute_stage, the hazard unit and memory_stage.
package mips_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned REG_W       = 5;
  // Byte-address bits below the word index.
  localparam int unsigned WORD_OFFSET = 2;

  // Memory-stage occupancy: idle when the wait-state counter is zero.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } mem_state_e;

  // Contents of the EX/MEM pipeline register.
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] write_data;
    logic [REG_W-1:0]  write_reg;
    logic              misalign;
  } ex_mem_t;

  // A word access must have its byte-offset bits clear.
  function automatic logic is_misaligned(input logic [WORD_OFFSET-1:0] byte_off);
    return byte_off != '0;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: DEPTH x 32 array.
// Ports:
//   clk_i   - write clock
//   we_i    - write enable, one word written per rising edge while high
//   addr_i  - word index (read and write share it)
//   wdata_i - write data
//   rdata_o - asynchronous read data at addr_i
// Contents are not reset.
module data_memory
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage.sv
// MIPS pipeline stage 4: EX/MEM register, data memory and wait-state stall.
// Ports:
//   clk, reset (sync, active-high)
//   RegWriteE, MemtoRegE, MemWriteE, ALUOutE, WriteDataE, WriteRegE - execute results
//   RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM  - registered M signals
//   ReadDataM - load data (0 unless an aligned load is in its final M cycle)
//   StallM    - memory busy, upstream stages hold
//   MisalignM - current M op is a misaligned load/store
// A memory op occupies M for WAIT_STATES+1 cycles; StallM covers the first WAIT_STATES.
module memory_stage
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 0,
  localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic [DATA_W-1:0] ALUOutE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [REG_W-1:0]  WriteRegE,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic              MemWriteM,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [REG_W-1:0]  WriteRegM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallM,
  output logic              MisalignM
);

  localparam int unsigned CntW = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_STATES);

  ex_mem_t           m_q, m_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  mem_state_e        state;
  logic              mem_op_e;
  logic              misalign_e;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_idx;
  logic [DATA_W-1:0] mem_rdata;

  assign mem_op_e   = MemWriteE | MemtoRegE;
  assign misalign_e = mem_op_e & is_misaligned(ALUOutE[WORD_OFFSET-1:0]);

  // The FSM state is just a view of the counter so StallM depends on cnt only.
  assign state = (cnt_q != '0) ? StBusy : StIdle;

  always_comb begin
    m_d   = m_q;
    cnt_d = cnt_q;
    unique case (state)
      StBusy: begin
        // Hold the register; E inputs are ignored while memory is busy.
        cnt_d = cnt_q - CntW'(1);
      end
      StIdle: begin
        m_d.reg_write  = RegWriteE;
        m_d.mem_to_reg = MemtoRegE;
        m_d.mem_write  = MemWriteE & ~misalign_e;
        m_d.alu_out    = ALUOutE;
        m_d.write_data = WriteDataE;
        m_d.write_reg  = WriteRegE;
        m_d.misalign   = misalign_e;
        cnt_d          = (mem_op_e && !misalign_e) ? CntLoad : '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q   <= '0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      cnt_q <= cnt_d;
    end
  end

  assign StallM  = (state == StBusy);
  assign mem_idx = m_q.alu_out[ADDR_W+WORD_OFFSET-1:WORD_OFFSET];
  // Exactly one write per store: only in the final, non-stalled M cycle.
  assign mem_we  = m_q.mem_write & ~m_q.misalign & ~StallM;

  data_memory #(
    .DEPTH(DEPTH)
  ) u_data_memory (
    .clk_i  (clk),
    .we_i   (mem_we),
    .addr_i (mem_idx),
    .wdata_i(m_q.write_data),
    .rdata_o(mem_rdata)
  );

  assign RegWriteM  = m_q.reg_write;
  assign MemtoRegM  = m_q.mem_to_reg;
  assign MemWriteM  = m_q.mem_write;
  assign ALUOutM    = m_q.alu_out;
  assign WriteDataM = m_q.write_data;
  assign WriteRegM  = m_q.write_reg;
  assign MisalignM  = m_q.misalign;
  // With both MemtoReg and MemWrite set the read sees the word before the commit edge.
  assign ReadDataM  = (m_q.mem_to_reg && !m_q.misalign && !StallM) ? mem_rdata : '0;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: three instances (WAIT_STATES 0, 2, 3) share one
// stimulus stream and are compared every cycle against a transaction model.
module tb_memory_stage;

  localparam int NI    = 3;
  localparam int DEPTH = 64;
  localparam int unsigned WS_TAB [NI] = '{0, 2, 3};

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, MemtoRegE, MemWriteE;
  logic [31:0] ALUOutE, WriteDataE;
  logic [4:0]  WriteRegE;

  logic        rw_m [NI];
  logic        mtr_m [NI];
  logic        mw_m [NI];
  logic        stall_m [NI];
  logic        mis_m [NI];
  logic [31:0] alu_m [NI];
  logic [31:0] wd_m [NI];
  logic [31:0] rd_m [NI];
  logic [4:0]  wr_m [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    memory_stage #(
      .DEPTH      (DEPTH),
      .WAIT_STATES(WS_TAB[g])
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .RegWriteE (RegWriteE),
      .MemtoRegE (MemtoRegE),
      .MemWriteE (MemWriteE),
      .ALUOutE   (ALUOutE),
      .WriteDataE(WriteDataE),
      .WriteRegE (WriteRegE),
      .RegWriteM (rw_m[g]),
      .MemtoRegM (mtr_m[g]),
      .MemWriteM (mw_m[g]),
      .ALUOutM   (alu_m[g]),
      .WriteDataM(wd_m[g]),
      .WriteRegM (wr_m[g]),
      .ReadDataM (rd_m[g]),
      .StallM    (stall_m[g]),
      .MisalignM (mis_m[g])
    );
  end

  // Reference model: the op currently in M and the cycles it still must stall.
  bit          e_rw [NI], e_mtr [NI], e_mw [NI], e_mis [NI];
  logic [31:0] e_alu [NI], e_wd [NI];
  logic [4:0]  e_wr [NI];
  int          e_wait [NI];
  logic [31:0] ref_mem [NI][DEPTH];
  bit          ref_known [NI][DEPTH];

  int          n_checks;
  int          n_errors;
  logic [31:0] ra;
  int unsigned rr;
  int          nw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] pre(input int i);
    return 32'hC0DE_0000 + i;
  endfunction

  function automatic bit any_busy();
    for (int k = 0; k < NI; k++) if (e_wait[k] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      e_rw[k] = 0; e_mtr[k] = 0; e_mw[k] = 0; e_mis[k] = 0;
      e_alu[k] = '0; e_wd[k] = '0; e_wr[k] = '0; e_wait[k] = 0;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      string       p;
      bit          st;
      bit          ld;
      logic [31:0] exp_rd;
      p      = $sformatf("ws%0d", WS_TAB[k]);
      st     = (e_wait[k] > 0);
      ld     = e_mtr[k] && !e_mis[k] && !st;
      exp_rd = ld ? ref_mem[k][widx(e_alu[k])] : 32'h0;
      check({p, "_regwrite"}, rw_m[k], e_rw[k]);
      check({p, "_memtoreg"}, mtr_m[k], e_mtr[k]);
      check({p, "_memwrite"}, mw_m[k], e_mw[k]);
      check({p, "_aluout"}, alu_m[k], e_alu[k]);
      check({p, "_wdata"}, wd_m[k], e_wd[k]);
      check({p, "_wreg"}, wr_m[k], e_wr[k]);
      check({p, "_stall"}, stall_m[k], st);
      check({p, "_misalign"}, mis_m[k], e_mis[k]);
      if (!ld || ref_known[k][widx(e_alu[k])]) check({p, "_rdata"}, rd_m[k], exp_rd);
    end
  endtask

  // Advance the model across one rising edge using the current E inputs.
  task automatic model_tick();
    for (int k = 0; k < NI; k++) begin
      bit memop, mis;
      if (e_mw[k] && !e_mis[k] && e_wait[k] == 0) begin
        ref_mem[k][widx(e_alu[k])]   = e_wd[k];
        ref_known[k][widx(e_alu[k])] = 1'b1;
      end
      if (reset) begin
        e_rw[k] = 0; e_mtr[k] = 0; e_mw[k] = 0; e_mis[k] = 0;
        e_alu[k] = '0; e_wd[k] = '0; e_wr[k] = '0; e_wait[k] = 0;
      end else if (e_wait[k] > 0) begin
        e_wait[k]--;
      end else begin
        memop     = MemWriteE || MemtoRegE;
        mis       = memop && (ALUOutE[1:0] != 2'b00);
        e_rw[k]   = RegWriteE;
        e_mtr[k]  = MemtoRegE;
        e_mw[k]   = MemWriteE && !mis;
        e_mis[k]  = mis;
        e_alu[k]  = ALUOutE;
        e_wd[k]   = WriteDataE;
        e_wr[k]   = WriteRegE;
        e_wait[k] = (memop && !mis) ? int'(WS_TAB[k]) : 0;
      end
    end
  endtask

  task automatic step();
    compare_all();
    model_tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit rw, input bit mtr, input bit mw, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] wr);
    RegWriteE  = rw;
    MemtoRegE  = mtr;
    MemWriteE  = mw;
    ALUOutE    = alu;
    WriteDataE = wd;
    WriteRegE  = wr;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0);
    while (any_busy() && n < 10) begin
      step();
      n++;
    end
    if (any_busy()) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0);
    model_clear();
    for (int k = 0; k < NI; k++) for (int i = 0; i < DEPTH; i++) ref_known[k][i] = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset clears everything even with live E inputs.
    reset = 1'b0;
    drive(1, 0, 1, 32'h0000_FFFF, 32'h5, 5'd7);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0);
    for (int k = 0; k < NI; k++) begin
      check("t1_aluout", alu_m[k], 32'h0);
      check("t1_regwrite", rw_m[k], 32'h0);
      check("t1_memwrite", mw_m[k], 32'h0);
      check("t1_wreg", wr_m[k], 32'h0);
      check("t1_stall", stall_m[k], 32'h0);
      check("t1_misalign", mis_m[k], 32'h0);
    end

    // Fill every word so later loads have known contents.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 1, 32'(i) << 2, pre(i), 5'd0);
      step();
      wait_idle();
    end

    // Plain ALU op passes through without stalling.
    drive(1, 0, 0, 32'h22, 32'h0, 5'd9);
    step();
    check("t2_aluout", alu_m[1], 32'h22);
    check("t2_wreg", wr_m[1], 32'd9);
    check("t2_rdata", rd_m[1], 32'h0);
    check("t2_stall", stall_m[1], 32'h0);
    wait_idle();

    // Store then load back-to-back on single-cycle memory.
    drive(0, 0, 1, 32'h8, 32'hDEAD_BEEF, 5'd0);
    step();
    check("t3_stall_sw", stall_m[0], 32'h0);
    drive(1, 1, 0, 32'h8, 32'h0, 5'd4);
    step();
    check("t3_stall_lw", stall_m[0], 32'h0);
    check("t3_rdata", rd_m[0], 32'hDEAD_BEEF);
    wait_idle();

    // Load with two wait states freezes M, then the next op is captured.
    drive(1, 1, 0, 32'h8, 32'h0, 5'd4);
    step();
    drive(1, 0, 0, 32'h55, 32'h0, 5'd3);
    check("t4_stall1", stall_m[1], 32'h1);
    check("t4_alu1", alu_m[1], 32'h8);
    check("t4_rdata1", rd_m[1], 32'h0);
    step();
    check("t4_stall2", stall_m[1], 32'h1);
    check("t4_alu2", alu_m[1], 32'h8);
    step();
    check("t4_stall3", stall_m[1], 32'h0);
    check("t4_rdata3", rd_m[1], 32'hDEAD_BEEF);
    check("t4_alu3", alu_m[1], 32'h8);
    step();
    check("t4_next_alu", alu_m[1], 32'h55);
    check("t4_next_wreg", wr_m[1], 32'd3);
    wait_idle();

    // Misaligned store is dropped and does not stall.
    drive(0, 0, 1, 32'h6, 32'h1234, 5'd0);
    step();
    check("t5_misalign", mis_m[1], 32'h1);
    check("t5_memwrite", mw_m[1], 32'h0);
    check("t5_stall", stall_m[1], 32'h0);
    wait_idle();
    drive(1, 1, 0, 32'h4, 32'h0, 5'd2);
    step();
    check("t5_rdata", rd_m[0], pre(1));
    wait_idle();

    // Reset in the middle of a stalled store discards it.
    drive(0, 0, 1, 32'hC, 32'hAAAA, 5'd0);
    step();
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0);
    step();
    check("t6_busy", stall_m[2], 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_stall", stall_m[2], 32'h0);
    check("t6_memwrite", mw_m[2], 32'h0);
    drive(1, 1, 0, 32'hC, 32'h0, 5'd1);
    step();
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0);
    nw = 0;
    while (stall_m[2] === 1'b1 && nw < 10) begin
      step();
      nw++;
    end
    if (nw >= 10) check("t6_timeout", 32'd1, 32'd0);
    check("t6_rdata", rd_m[2], pre(3));
    wait_idle();

    // Random traffic, including wrapped addresses, illegal encodings and resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      rr    = $urandom_range(0, 9);
      ra    = 32'($urandom_range(0, 127)) << 2;
      if ($urandom_range(0, 5) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      if (rr < 3)      drive(1, 0, 0, $urandom, $urandom, 5'($urandom));
      else if (rr < 6) drive(1, 1, 0, ra, $urandom, 5'($urandom));
      else if (rr < 9) drive(0, 0, 1, ra, $urandom, 5'($urandom));
      else             drive(1, 1, 1, ra, $urandom, 5'($urandom));
      step();
    end
    reset = 1'b0;
    wait_idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
